// File: rtl/seq_multiplier32.sv
// rtl/seq_multiplier32.sv - sequential unsigned shift-and-add multiplier, WIDTH cycles per product
// Each RUN cycle adds the multiplicand into the upper half when the multiplier LSB is set, then shifts right.
module ripple_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] b_eff;

  always_comb begin
    b_eff    = b ^ {WIDTH{sub}};
    carry    = '0;
    sum      = '0;
    carry[0] = cin ^ sub;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]       = a[i] ^ b_eff[i] ^ carry[i];
      carry[i+1]   = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end
  end

  assign cout     = carry[WIDTH];
  assign overflow = carry[WIDTH] ^ carry[WIDTH-1];
endmodule

module seq_multiplier32 #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     operandA,
  input  logic [WIDTH-1:0]     operandB,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 hi_nonzero
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic               add_ovf_unused;
  logic [WIDTH-1:0]   step_s;
  logic               step_c;
  logic [2*WIDTH-1:0] next_acc;
  logic               accept;

  ripple_addsub #(.WIDTH(WIDTH)) u_adder (
    .a        (acc_hi),
    .b        (mcand),
    .cin      (1'b0),
    .sub      (1'b0),
    .sum      (add_sum),
    .cout     (add_cout),
    .overflow (add_ovf_unused)
  );

  // Carry-out is kept and becomes the new MSB of acc_hi after the shift.
  assign {step_c, step_s} = acc_lo[0] ? {add_cout, add_sum} : {1'b0, acc_hi};
  assign next_acc         = {step_c, step_s, acc_lo[WIDTH-1:1]};

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mcand      <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      cnt        <= '0;
      product    <= '0;
      hi_nonzero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            mcand  <= operandA;
            acc_hi <= '0;
            acc_lo <= operandB;
            cnt    <= '0;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          acc_hi <= next_acc[2*WIDTH-1:WIDTH];
          acc_lo <= next_acc[WIDTH-1:0];
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state      <= DONE;
            product    <= next_acc;
            hi_nonzero <= |next_acc[2*WIDTH-1:WIDTH];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_multiplier32.sv
// tb/tb_seq_multiplier32.sv - randomized self-checking bench for seq_multiplier32
module tb_seq_multiplier32;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic        hi_nonzero;

  int          n_checks;
  int          n_fail;
  logic [63:0] prev_prod;

  seq_multiplier32 #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .operandA   (operandA),
    .operandB   (operandB),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .hi_nonzero (hi_nonzero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, {63'b0, busy}, 64'd0);
    check({tag, "_done"}, {63'b0, done}, 64'd0);
    check({tag, "_prod"}, product, prev_prod);
  endtask

  // Called at a negedge; drives start there. poke_cycle re-asserts start mid-run,
  // abort_cycle pulls reset mid-run. Returns at the negedge of the done cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int poke_cycle, input int abort_cycle);
    logic [63:0] exp;
    exp      = {32'b0, a} * {32'b0, b};
    start    = 1'b1;
    operandA = a;
    operandB = b;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == poke_cycle) begin
        start    = 1'b1;
        operandA = 32'd100;
        operandB = 32'd100;
      end else begin
        start    = 1'b0;
        operandA = $urandom;
        operandB = $urandom;
      end
      check("run_busy", {63'b0, busy}, 64'd1);
      check("run_done", {63'b0, done}, 64'd0);
      check("run_hold", product, prev_prod);
      if (i == abort_cycle) begin
        #2 rst_n = 1'b0;
        #1;
        prev_prod = '0;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_prod", product, 64'd0);
        check("rst_hinz", {63'b0, hi_nonzero}, 64'd0);
        @(negedge clk);
        check_idle_outputs("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", {63'b0, done}, 64'd1);
    check("done_busy", {63'b0, busy}, 64'd0);
    check("product", product, exp);
    check("hi_nonzero", {63'b0, hi_nonzero}, {63'b0, (exp[63:32] != 32'd0)});
    prev_prod = exp;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    prev_prod = '0;
    rst_n     = 1'b0;
    start     = 1'b0;
    operandA  = '0;
    operandB  = '0;
    #23;
    check_idle_outputs("reset");
    check("reset_hinz", {63'b0, hi_nonzero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    run_op(32'd3, 32'd5, 0, 0);
    @(negedge clk);
    check_idle_outputs("after_basic");

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    @(negedge clk);
    run_op(32'd0, 32'hDEAD_BEEF, 0, 0);
    @(negedge clk);
    run_op(32'h8000_0000, 32'd2, 0, 0);
    @(negedge clk);

    run_op(32'd7, 32'd9, 10, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_outputs("no_second_done");
    end

    run_op(32'h1234_5678, 32'h9ABC_DEF0, 0, 15);
    run_op(32'd6, 32'd7, 0, 0);
    @(negedge clk);

    run_op(32'd2, 32'd3, 0, 0);
    run_op(32'd11, 32'd13, 0, 0);
    @(negedge clk);
    check_idle_outputs("after_b2b");

    for (int n = 0; n < 8; n++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (n == 3) rb = $urandom_range(255, 0);
      if (n == 5) ra = 32'hFFFF_FFFF;
      run_op(ra, rb, 0, 0);
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end
    @(negedge clk);
    check_idle_outputs("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
